// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants for the bit-serial subtractor.
// Holds the default operand width, the FSM state encodings and a small
// helper that computes two's-complement overflow of a subtraction.
package serial_sub_pkg;

  // Default operand/result width. Legal range is 2..32.
  localparam int WIDTH_DEFAULT = 8;

  // FSM state encodings. Kept as plain 2-bit constants so that older
  // tools and netlist viewers show stable, readable values.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  // Overflow of A-B: the operands have different signs and the result
  // sign differs from the sign of A.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor, purely combinational.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing A-B modulo 2^WIDTH, one bit
// per clock, LSB first, through a single full_sub cell.
// Ports: clk, reset (sync, active-high), start, a_in, b_in in;
//        busy, done, diff, borrow, ovf out.
// Timing: start accepted in IDLE at edge k, bits processed on edges
// k+1..k+WIDTH, done high for the one cycle after edge k+WIDTH.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // Counter must be able to hold 0..WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bin_q;
  logic [CW-1:0]    cnt;

  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // The current bit always sits at position 0 of the operand shifters.
  full_sub u_full_sub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Difference bits enter at the MSB end so that after WIDTH shifts the
  // first (LSB) bit has walked down to position 0.
  assign res_next = {bit_d, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Status flags come straight from the registered state: no path from
  // start to done/busy.
  assign busy = (state == SHIFT);
  assign done = (state == FIN);

  // FSM and datapath shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bin_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bin_q  <= bit_bout;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            state <= FIN;
          end
        end
        FIN: begin
          // One-cycle result strobe; start is deliberately not looked at.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Visible results only change on the edge entering FIN, so partial
  // bits never show on diff. On that edge a_sr[0]/b_sr[0] hold the
  // original operand MSBs and bit_d is the result MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      diff   <= res_next;
      borrow <= bit_bout;
      ovf    <= sub_ovf(a_sr[0], b_sr[0], bit_d);
    end
  end

endmodule
